// File: rtl/systolic_skew_fifo_bank.sv
// Row FIFO feeding per-lane delay lines: lane k reaches the array k shifts after lane 0
// (diagonal skew), or all lanes together when skew mode is off.
module systolic_skew_fifo_bank #(
  parameter int ARRAY_DIM = 4,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          load,
  input  logic [DATA_W*ARRAY_DIM-1:0]   load_values,
  output logic                          load_ready,
  input  logic                          shift,
  input  logic                          flush,
  input  logic                          skew_en,
  output logic [DATA_W*ARRAY_DIM-1:0]   out,
  output logic [ARRAY_DIM-1:0]          out_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ROW_W = DATA_W*ARRAY_DIM;

  logic [ROW_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 skew_mode_reg;
  logic                 push;
  logic                 pop;
  logic [ROW_W-1:0]     pop_row;
  logic [ARRAY_DIM-1:0] lane_busy;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign load_ready = !full || (shift && !empty);
  // flush overrides both sides of the handshake
  assign pop        = shift && !empty && !flush;
  assign push       = load && load_ready && !flush;
  assign pop_row    = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= load_values;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Mode may only change once nothing is in flight, so rows never straddle two alignments.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       skew_mode_reg <= 1'b1;
    else if (lane_busy == '0 && !pop) skew_mode_reg <= skew_en;
  end

  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
    logic [DATA_W-1:0] data_reg [gi+1];
    logic [gi:0]       valid_reg;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        valid_reg <= '0;
        for (int s = 0; s <= gi; s++) data_reg[s] <= '0;
      end else if (flush) begin
        valid_reg <= '0;
        for (int s = 0; s <= gi; s++) data_reg[s] <= '0;
      end else if (shift) begin
        valid_reg[0] <= pop;
        data_reg[0]  <= pop ? pop_row[gi*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= gi; s++) begin
          valid_reg[s] <= valid_reg[s-1];
          data_reg[s]  <= data_reg[s-1];
        end
      end
    end

    assign lane_busy[gi]              = |valid_reg;
    assign out[gi*DATA_W +: DATA_W]   = skew_mode_reg ? data_reg[gi]  : data_reg[0];
    assign out_valid[gi]              = skew_mode_reg ? valid_reg[gi] : valid_reg[0];
  end

endmodule

// File: tb/tb_systolic_skew_fifo_bank.sv
// Directed stimulus with a per-lane scoreboard: accepted rows are queued, and a monitor
// compares every valid lane element after each shift edge against the queued rows in order.
module tb_systolic_skew_fifo_bank;
  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 4;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           load = 1'b0;
  logic           shift = 1'b0;
  logic           flush = 1'b0;
  logic           skew_en = 1'b1;
  logic [N*W-1:0] load_values = '0;
  logic [N*W-1:0] out;
  logic [N-1:0]   out_valid;
  logic           load_ready;
  logic           full;
  logic           empty;
  logic [2:0]     count;

  int             errors = 0;
  int             checks = 0;
  logic [N*W-1:0] rows [$];
  int             lane_idx [N];
  int             model_cnt = 0;

  systolic_skew_fifo_bank #(.ARRAY_DIM(N), .DATA_W(W), .DEPTH(D)) dut (
    .CLK(CLK), .nRST(nRST), .load(load), .load_values(load_values),
    .load_ready(load_ready), .shift(shift), .flush(flush), .skew_en(skew_en),
    .out(out), .out_valid(out_valid), .full(full), .empty(empty), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [N*W-1:0] row(input logic [15:0] base);
    return {base + 16'd4, base + 16'd3, base + 16'd2, base + 16'd1};
  endfunction

  task automatic clear_sb();
    rows.delete();
    for (int k = 0; k < N; k++) lane_idx[k] = 0;
    model_cnt = 0;
  endtask

  // Drive one cycle at a falling edge; model acceptance; return at the next falling edge.
  task automatic cyc(input logic l, input logic [N*W-1:0] v, input logic s, input logic f);
    int pop_m;
    int acc;
    load = l; load_values = v; shift = s; flush = f;
    if (f) begin
      clear_sb();
    end else begin
      pop_m = (s && model_cnt > 0) ? 1 : 0;
      acc   = (l && (model_cnt < D || pop_m == 1)) ? 1 : 0;
      if (acc == 1) rows.push_back(v);
      model_cnt = model_cnt + acc - pop_m;
    end
    @(negedge CLK);
    load = 1'b0; shift = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_drained(input string name);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s lane%0d rows emitted", name, k), 64'(lane_idx[k]), 64'(rows.size()));
  endtask

  // Monitor: after each shift edge, each valid lane must present its next queued element.
  initial begin
    bit             sh;
    logic [N*W-1:0] exp_row;
    forever begin
      @(posedge CLK);
      sh = shift && !flush && nRST;
      #1;
      if (sh) begin
        for (int k = 0; k < N; k++) begin
          if (out_valid[k]) begin
            if (lane_idx[k] >= rows.size()) begin
              checks++;
              errors++;
              $display("FAIL sb lane%0d: got valid data %0h expected no valid output", k, out[k*W +: W]);
            end else begin
              exp_row = rows[lane_idx[k]];
              chk($sformatf("sb lane%0d row%0d", k, lane_idx[k]), 64'(out[k*W +: W]), 64'(exp_row[k*W +: W]));
              lane_idx[k]++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_sb();
    @(negedge CLK);
    chk("reset count", 64'(count), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    nRST = 1'b1;
    @(negedge CLK);

    // Asynchronous reset in the middle of traffic
    cyc(1'b1, row(16'h0200), 1'b0, 1'b0);
    cyc(1'b1, row(16'h0210), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    #2 nRST = 1'b0;
    #1;
    chk("async rst out", out, 64'd0);
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst count", 64'(count), 64'd0);
    chk("async rst empty", 64'(empty), 64'd1);
    chk("async rst full", 64'(full), 64'd0);
    chk("async rst load_ready", 64'(load_ready), 64'd1);
    clear_sb();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Skew path
    cyc(1'b1, row(16'h0000), 1'b0, 1'b0);
    cyc(1'b1, row(16'h0010), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e1 lane0", 64'(out[15:0]), 64'h0001);
    chk("skew e1 valid", 64'(out_valid), 64'b0001);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e2 lane0", 64'(out[15:0]), 64'h0011);
    chk("skew e2 lane1", 64'(out[31:16]), 64'h0002);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e3 valid", 64'(out_valid), 64'b0110);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e4 lane3", 64'(out[63:48]), 64'h0004);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e5 lane3", 64'(out[63:48]), 64'h0014);
    chk("skew e5 lane0 valid", 64'(out_valid[0]), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skew e6 valid", 64'(out_valid), 64'd0);
    chk_drained("skew");

    // Full and pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, row(16'h0100 + 16'(i * 16)), 1'b0, 1'b0);
    chk("full flag", 64'(full), 64'd1);
    chk("full count", 64'(count), 64'd4);
    chk("full load_ready", 64'(load_ready), 64'd0);
    cyc(1'b1, row(16'h0500), 1'b0, 1'b0);
    chk("dropped load count", 64'(count), 64'd4);
    cyc(1'b1, row(16'h0140), 1'b1, 1'b0);
    chk("load+shift count", 64'(count), 64'd4);
    chk("load+shift full", 64'(full), 64'd1);
    chk("load+shift lane0", 64'(out[15:0]), 64'h0101);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pop all empty", 64'(empty), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk_drained("wrap");

    // Stall mid-stream
    cyc(1'b1, row(16'h0600), 1'b0, 1'b0);
    cyc(1'b1, row(16'h0610), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("stall%0d out", i), out, 64'h0000_0000_0602_0611);
      chk($sformatf("stall%0d valid", i), 64'(out_valid), 64'b0011);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stall resume valid", 64'(out_valid), 64'd0);
    chk_drained("stall");

    // Bypass and deferred mode change
    skew_en = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, row(16'h0700), 1'b0, 1'b0);
    cyc(1'b1, row(16'h0710), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bypass e1 out", out, 64'h0704_0703_0702_0701);
    chk("bypass e1 valid", 64'(out_valid), 64'b1111);
    skew_en = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bypass e2 out", out, 64'h0714_0713_0712_0711);
    chk("bypass e2 valid", 64'(out_valid), 64'b1111);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bypass e3 valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, row(16'h0800), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("reskew e1 valid", 64'(out_valid), 64'b0001);
    chk("reskew e1 lane0", 64'(out[15:0]), 64'h0801);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk_drained("mode");

    // Flush beats simultaneous load and shift
    for (int i = 0; i < 3; i++) cyc(1'b1, row(16'h0900 + 16'(i * 16)), 1'b0, 1'b0);
    chk("pre-flush count", 64'(count), 64'd3);
    cyc(1'b1, row(16'h0A00), 1'b1, 1'b1);
    chk("flush count", 64'(count), 64'd0);
    chk("flush empty", 64'(empty), 64'd1);
    chk("flush valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("post-flush valid", 64'(out_valid), 64'd0);
    cyc(1'b1, row(16'h0B00), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("post-flush lane0", 64'(out[15:0]), 64'h0B01);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk_drained("flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_skew_fifo_bank.md
Name: systolic_skew_fifo_bank

Overview:
Parametrised input staging bank for one edge of the systolic array. It buffers up to DEPTH full matrix rows (ARRAY_DIM lanes of DATA_W each) in a circular row FIFO. On each shift it pops one row and feeds it through per-lane delay lines, so lane k reaches the array k cycles after lane 0 (diagonal skew). It generalises the single-lane load/shift FIFO to multi-lane output with a handshake, occupancy flags, a skew-bypass mode and a flush.

Parameters:
ARRAY_DIM, 4, number of lanes (array rows or columns)
DATA_W, 16, bits per element (FP16)
DEPTH, 4, row slots in the FIFO; power of two, >=2

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
load  input  1  request to write load_values as one row
load_values  input  DATA_W*ARRAY_DIM  row to write; lane k = bits [k*DATA_W +: DATA_W]
load_ready  output  1  write will be accepted this cycle
shift  input  1  advance the skew pipeline one step; pops a row if not empty
flush  input  1  synchronous clear of FIFO and delay lines
skew_en  input  1  1 = diagonal skew, 0 = all lanes aligned; quasi-static
out  output  DATA_W*ARRAY_DIM  lane k element presented to the array
out_valid  output  ARRAY_DIM  per-lane valid for out
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  $clog2(DEPTH+1)  rows held in the FIFO

Behaviour:
- Reset (nRST low, async): pointers, count, all delay stages, out and out_valid go to 0. skew_mode register goes to 1. Outputs: empty=1, full=0, load_ready=1. Reset mid-operation discards everything.
- pop = shift && !empty.
- push = load && load_ready.
- load_ready = !full || pop. A write into a full FIFO in the same cycle as a pop is accepted; count is unchanged.
- Write pointer advances on push; read pointer advances on pop. Both wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- A load that is not accepted is dropped silently; no state changes.
- A push into an empty FIFO is not visible to pop until the next cycle; no write-to-read bypass.
- Delay lines:
  - Lane k has k+1 register stages, each holding {valid, data}.
  - The stages advance only on cycles with shift=1. With shift=0, every stage and every output holds.
  - Stage 0 of lane k loads the popped row's element k with valid=1.
  - If shift=1 and the FIFO is empty, stage 0 loads data 0 with valid=0. This drains the skew tail: ARRAY_DIM-1 extra shifts empty the pipeline.
  - out/out_valid for lane k = last stage of lane k when skew_mode=1, else stage 0 of lane k.
  - Latency with skew_mode=1: lane k shows row r after k+1 shift edges following the pop of r.
  - Latency with skew_mode=0: all lanes show row r after 1 shift edge.
- skew_mode register:
  - Loads skew_en only when every stage valid bit in all lanes is 0 and no pop is occurring.
  - Otherwise skew_en changes are ignored until the pipeline drains.
- flush:
  - Takes priority over load and shift in the same cycle.
  - Clears pointers, count and all stages to 0. Load and shift in that cycle are ignored.
  - Next cycle: empty=1, out_valid=0.
- No arithmetic on data; elements pass bit-exact.

Test Plan:
- Reset: assert nRST=0 mid-stream -> out=0, out_valid=0000, count=0, empty=1, full=0, load_ready=1 immediately, without waiting for a clock edge.
- Skew path:
  - Setup: skew_en=1; load R0 = lanes {0x0001,0x0002,0x0003,0x0004} then R1 = {0x0011,0x0012,0x0013,0x0014}; then shift held high.
  - After shift edge 1: lane0 = 0x0001, out_valid = 0001.
  - After edge 2: lane0 = 0x0011, lane1 = 0x0002.
  - After edge 4: lane3 = 0x0004.
  - After edge 5: lane3 = 0x0014, lane0 valid = 0.
  - After edge 6: out_valid = 0000.
- Full/wrap:
  - Load 4 rows with no shift -> full=1, count=4, load_ready=0.
  - 5th load alone -> dropped, count=4.
  - Load plus shift together -> accepted, count stays 4, pointers wrap.
  - Pop all 4 rows -> rows emerge in order, then empty=1.
- Stall: with skew_en=1 mid-stream, drop shift for 3 cycles -> out and out_valid hold exactly; resume shift -> sequence continues with no lost or duplicated rows.
- Bypass/mode change:
  - skew_en=0, R0 loaded, one shift -> all four lanes show R0 together, out_valid = 1111.
  - Toggle skew_en to 1 while any stage is valid -> alignment unchanged until out_valid reaches 0000; next row is then skewed.
- Flush: flush=1 with load=1 and shift=1, 3 rows held -> next cycle count=0, empty=1, out_valid=0000, and the loaded row is absent.
